// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch unit.
//
// Issues one read per instruction to instruction memory, holds the returned
// word for the consumer until it is retired, then advances pc (sequential
// or branch redirect) and fetches again.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   mem_req, mem_addr   : memory read request / address (address = pc)
//   mem_ack, mem_rdata  : memory read data valid / instruction word
//   instruction, pc     : held instruction word and its address
//   instr_valid         : instruction is valid for the consumer
//   instr_ready         : consumer retires the held instruction
//   branch_taken/target : redirect applied on retire
//   fetch_err           : sticky fetch timeout flag
//
// Build option
//   FETCH_TIMEOUT_EN : when defined, a FETCH that sees no mem_ack for
//                      TIMEOUT_CYCLES cycles enters ERR and sets fetch_err.
//                      When undefined, FETCH waits forever and fetch_err = 0.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC       = 64'h0000_0000_0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        fetch_err
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t state;

    // A zero-cycle timeout is meaningless; reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("instruction_fetch: TIMEOUT_CYCLES must be at least 1");
    end

    // The request address is always the pc register.
    assign mem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tcnt;
    logic             err_q;

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // Fetch FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tcnt        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end

                FETCH: begin
                    if (mem_ack) begin
                        // An ack in the limit cycle still wins over the timeout.
                        instruction <= mem_rdata;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= VALID;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tcnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= ERR;
                    end else begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
`endif
                end

                VALID: begin
                    if (instr_ready) begin
                        // Redirect targets are forced to word alignment.
                        pc          <= branch_taken ? {branch_target[63:2], 2'b00}
                                                    : pc + 64'd4;
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        state       <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                        tcnt        <= '0;
`endif
                    end
                end

                ERR: begin
                    state <= ERR;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed + randomized self-checking bench for
// instruction_fetch. A transaction-level model predicts every output each
// cycle; directed sections additionally pin key values with literals.
module tb_instruction_fetch;

    localparam logic [63:0] RST_PC  = 64'h0000_0000_0000_1000;
    localparam int unsigned TMO     = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    instruction_fetch #(
        .RESET_PC      (RST_PC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instruction  (instruction),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    // Reference model: what the consumer and memory must observe.
    bit          m_boot;   // first cycle out of reset, no request yet
    bit          m_req;    // a read is outstanding
    bit          m_valid;  // an instruction is held for the consumer
    bit          m_err;    // fetch timed out
    int          m_wait;   // unacknowledged request cycles so far
    logic [63:0] m_pc;
    logic [31:0] m_instr;

    function automatic void model_step();
        if (reset) begin
            m_boot = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            m_wait = 0; m_pc = RST_PC; m_instr = NOP;
        end else if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1; m_wait = 0;
        end else if (m_req) begin
            if (mem_ack) begin
                m_instr = mem_rdata; m_req = 1'b0; m_valid = 1'b1;
            end else begin
                m_wait++;
                if (TO_EN && m_wait == TMO) begin
                    m_req = 1'b0; m_err = 1'b1;
                end
            end
        end else if (m_valid && instr_ready) begin
            m_pc    = branch_taken ? {branch_target[63:2], 2'b00} : m_pc + 64'd4;
            m_valid = 1'b0; m_req = 1'b1; m_wait = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare();
        chk("mem_req", 64'(mem_req), 64'(m_req));
        chk("instr_valid", 64'(instr_valid), 64'(m_valid));
        chk("fetch_err", 64'(fetch_err), 64'(m_err));
        chk("instruction", 64'(instruction), 64'(m_instr));
        chk("pc", pc, m_pc);
        if (m_req) chk("mem_addr", mem_addr, m_pc);
    endtask

    // Advance one clock with the inputs currently driven, then compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic quiet();
        reset = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // From a fetch in progress: ack with data, then retire with the redirect.
    task automatic ack_and_retire(input logic [31:0] data, input logic bt,
                                  input logic [63:0] tgt);
        quiet(); mem_ack = 1'b1; mem_rdata = data;
        cycle();
        quiet(); instr_ready = 1'b1; branch_taken = bt; branch_target = tgt;
        cycle();
        quiet();
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst pc", pc, 64'h1000);
        chk("rst instruction", 64'(instruction), 64'h13);
        chk("rst instr_valid", 64'(instr_valid), 64'h0);
        chk("rst mem_req", 64'(mem_req), 64'h0);
        chk("rst fetch_err", 64'(fetch_err), 64'h0);

        // Leave reset: one idle cycle, then request at RESET_PC.
        quiet();
        cycle();
        chk("first req", 64'(mem_req), 64'h1);
        chk("first addr", mem_addr, 64'h1000);
        cycle();
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        // A junk redirect during FETCH must have no effect.
        branch_taken = 1'b1; branch_target = 64'h5000;
        cycle();
        quiet();
        chk("valid after ack", 64'(instr_valid), 64'h1);
        chk("captured word", 64'(instruction), 64'h0050_0093);
        chk("req dropped", 64'(mem_req), 64'h0);

        // Consumer stalls for 5 cycles with noise on ack and branch inputs.
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            branch_taken = 1'b1; branch_target = {$urandom, $urandom};
            cycle();
        end
        quiet();
        chk("stall instruction", 64'(instruction), 64'h0050_0093);
        chk("stall pc", pc, 64'h1000);

        // Sequential retire.
        instr_ready = 1'b1;
        cycle();
        quiet();
        chk("seq addr", mem_addr, 64'h1004);

        // Branch pulse while fetching is ignored.
        branch_taken = 1'b1; branch_target = 64'h5000; instr_ready = 1'b1;
        cycle();
        quiet();
        chk("fetch branch ignored", mem_addr, 64'h1004);

        ack_and_retire(32'h1111_1111, 1'b1, 64'h2006);
        chk("branch addr", mem_addr, 64'h2004);

        ack_and_retire(32'h2222_2222, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("near wrap addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        ack_and_retire(32'h3333_3333, 1'b0, 64'h0);
        chk("wrap addr", mem_addr, 64'h0);
        chk("wrap req", 64'(mem_req), 64'h1);

        // Reset wins over a simultaneous ack.
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        cycle();
        quiet();
        chk("rst+ack instruction", 64'(instruction), 64'h13);
        chk("rst+ack valid", 64'(instr_valid), 64'h0);
        chk("rst+ack pc", pc, 64'h1000);
        chk("rst+ack req", 64'(mem_req), 64'h0);

`ifdef FETCH_TIMEOUT_EN
        // No ack for TIMEOUT cycles -> error.
        cycle();
        for (int i = 0; i < 15; i++) cycle();
        chk("pre-timeout err", 64'(fetch_err), 64'h0);
        chk("pre-timeout req", 64'(mem_req), 64'h1);
        cycle();
        chk("timeout err", 64'(fetch_err), 64'h1);
        chk("timeout req", 64'(mem_req), 64'h0);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        quiet();
        chk("err sticky", 64'(fetch_err), 64'h1);
        chk("err no valid", 64'(instr_valid), 64'h0);
        do_reset();
        chk("err cleared", 64'(fetch_err), 64'h0);
        // Ack in the limit cycle is captured.
        cycle();
        for (int i = 0; i < 15; i++) cycle();
        mem_ack = 1'b1; mem_rdata = 32'h0ABC_D123;
        cycle();
        quiet();
        chk("late ack valid", 64'(instr_valid), 64'h1);
        chk("late ack word", 64'(instruction), 64'h0ABC_D123);
        chk("late ack no err", 64'(fetch_err), 64'h0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            mem_ack       = ($urandom_range(0, 2) == 0);
            mem_rdata     = $urandom;
            instr_ready   = $urandom_range(0, 1) == 1;
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0)
                branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_0000_0000, is the first fetch address after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of FETCH cycles without mem_ack; it is used only with FETCH_TIMEOUT_EN.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port mem_req, output, 1 bit: instruction-memory read request.
REQ-006 Port mem_addr, output, 64 bits: read address; equals pc while mem_req=1.
REQ-007 Port mem_ack, input, 1 bit: read data valid this cycle.
REQ-008 Port mem_rdata, input, 32 bits: instruction word, sampled when mem_ack=1.
REQ-009 Port instruction, output, 32 bits: registered instruction word, fed directly to the sign-extension stage.
REQ-010 Port pc, output, 64 bits: address of the held or pending instruction.
REQ-011 Port instr_valid, output, 1 bit: instruction is valid for the consumer.
REQ-012 Port instr_ready, input, 1 bit: the consumer retires the instruction.
REQ-013 Port branch_taken, input, 1 bit: redirect request, qualified by the retire handshake.
REQ-014 Port branch_target, input, 64 bits: redirect address.
REQ-015 Port fetch_err, output, 1 bit: sticky fetch timeout flag.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, VALID and ERR.
REQ-017 IDLE: the FSM SHALL move to FETCH on the next edge unconditionally; all outputs are deasserted.
REQ-018 FETCH: mem_req=1 and mem_addr=pc; on mem_ack=1, instruction<=mem_rdata and the FSM moves to VALID.
REQ-019 Fetch latency: instr_valid SHALL assert on the cycle after the mem_ack cycle.
REQ-020 VALID: instr_valid=1, instruction and pc SHALL be held stable, and mem_req=0.
REQ-021 In VALID with instr_ready=1, pc SHALL update and the FSM returns to FETCH on that edge.
REQ-022 The pc update on retire SHALL be {branch_target[63:2],2'b00} when branch_taken=1, else pc+4.
REQ-023 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-024 branch_taken and branch_target SHALL be ignored unless the FSM is in VALID with instr_ready=1.
REQ-025 mem_ack SHALL be ignored outside FETCH; mem_rdata SHALL be ignored when mem_ack=0.
REQ-026 instr_ready SHALL be ignored outside VALID.
REQ-027 A retire followed by the next instruction SHALL take at least 2 cycles (VALID -> FETCH -> ack).
REQ-028 ERR: mem_req=0 and instr_valid=0; the FSM remains in ERR until reset.

Reset
REQ-029 On reset=1 at an edge, the following SHALL apply: state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP), instr_valid=0, mem_req=0, fetch_err=0, and the timeout counter cleared.
REQ-030 Reset asserted during FETCH SHALL deassert mem_req on that same edge; an ack in the reset cycle is discarded.
REQ-031 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-032 The macro FETCH_TIMEOUT_EN, when defined, SHALL enable a counter that increments each FETCH cycle without mem_ack and clears on entry to FETCH.
REQ-033 With FETCH_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES without ack, the FSM SHALL enter ERR and set fetch_err=1; an ack in the limit cycle wins and is captured normally.
REQ-034 Without FETCH_TIMEOUT_EN, there SHALL be no counter, fetch_err SHALL be tied to 0, ERR SHALL be unreachable, and FETCH SHALL wait indefinitely.

Verification
REQ-035 Reset release with RESET_PC=0x1000 and ack after 3 cycles carrying 0x00500093 -> mem_addr=0x1000, instruction=0x00500093, instr_valid rises one cycle after ack.
REQ-036 instr_ready=1 with branch_taken=0 at pc=0x1000 -> next mem_addr=0x1004; instr_ready held 0 for 5 cycles -> instruction and pc unchanged.
REQ-037 Retire with branch_taken=1 and branch_target=0x2006 -> pc=0x2004; branch_taken pulsed during FETCH -> no effect.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC retired -> next mem_addr=0x0.
REQ-039 FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no ack -> fetch_err=1 and mem_req=0 after 16 cycles; ack on cycle 16 -> captured and no error; reset -> fetch_err=0.
REQ-040 Reset asserted during an outstanding FETCH with simultaneous ack -> instruction=0x00000013, instr_valid=0, pc=RESET_PC.
